// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks every architectural integer register through a shared combinational
// read port and streams each one out as an (index, data) beat on a
// valid/ready interface. Used to produce difftest / trace register dumps.
//
// The read port is driven only while the walk is in progress. Outside RUN the
// address is parked at zero, so an external mux can hand the port back to the core.
// Each beat captures rdata on the edge that loads it. Later register writes
// are not tracked, so a dump is not a coherent snapshot.

module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_NUM    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The index counter is one bit wider than an address so it can hold
  // REG_NUM itself. That value marks "every register has been loaded".
  localparam logic [ADDR_WIDTH:0] IDX_END  = (ADDR_WIDTH + 1)'(REG_NUM);
  localparam logic [ADDR_WIDTH:0] IDX_ZERO = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH:0] IDX_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                  state_r;
  state_e                  state_s;
  logic [ADDR_WIDTH:0]     idx_r;
  logic [ADDR_WIDTH:0]     idx_s;
  logic                    out_valid_r;
  logic                    out_valid_s;
  logic [ADDR_WIDTH-1:0]   out_idx_r;
  logic [ADDR_WIDTH-1:0]   out_idx_s;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic [DATA_WIDTH-1:0]   out_data_s;
  logic                    busy_r;
  logic                    busy_s;
  logic                    done_r;
  logic                    done_s;

  // The output slot can take a new beat when it is empty, or when the beat it
  // holds is being consumed on this edge.
  logic                    slot_free_s;
  logic                    load_s;

  assign slot_free_s = (~out_valid_r) | out_ready;
  assign load_s      = (state_r == ST_RUN) && (idx_r < IDX_END) && slot_free_s;

  // Drive the read port only during the walk. It is parked at zero otherwise.
  assign raddr = (state_r == ST_RUN) ? idx_r[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};

  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Next-state, index and output-slot logic. abort takes priority over load/transfer.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    out_valid_s = out_valid_r;
    out_idx_s   = out_idx_r;
    out_data_s  = out_data_r;

    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_s = ST_RUN;
          idx_s   = IDX_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_s     = ST_IDLE;
          idx_s       = IDX_ZERO;
          out_valid_s = 1'b0;
        end else if ((idx_r == IDX_END) && slot_free_s) begin
          // The last beat, if any is pending, is consumed on this edge.
          state_s     = ST_DONE;
          out_valid_s = 1'b0;
        end else if (load_s) begin
          out_data_s  = rdata;
          out_idx_s   = idx_r[ADDR_WIDTH-1:0];
          out_valid_s = 1'b1;
          idx_s       = idx_r + IDX_ONE;
        end else begin
          // Stalled by the consumer: hold the pending beat unchanged.
          state_s = ST_RUN;
        end
      end

      ST_DONE: begin
        // start and abort are both ignored here.
        state_s = ST_IDLE;
      end

      default: begin
        state_s     = ST_IDLE;
        idx_s       = IDX_ZERO;
        out_valid_s = 1'b0;
      end
    endcase

    // busy and done are registered decodes of the next state, so they line
    // up exactly with the state register.
    busy_s = (state_s == ST_RUN) || (state_s == ST_DONE);
    done_s = (state_s == ST_DONE);
  end

  // State register and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= IDX_ZERO;
      out_valid_r <= 1'b0;
      out_idx_r   <= {ADDR_WIDTH{1'b0}};
      out_data_r  <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      out_valid_r <= out_valid_s;
      out_idx_r   <= out_idx_s;
      out_data_r  <= out_data_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader. A register-file array answers
// raddr combinationally. The expected dump is the sequence 0..31 with that
// array's contents, and the bench walks it alongside the consumer handshake.

module tb_regfile_dump_reader;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RN = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [RN];

  int n_tests;
  int n_fail;
  int exp_idx;
  logic fired;
  logic done_now;

  regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM(RN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  assign rdata = regs[raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: score any transfer at this edge against the expected order,
  // then sample #1 after the edge and check that a stalled beat held stable.
  task automatic step();
    logic          stalled;
    logic          aborting;
    logic [AW-1:0] p_idx;
    logic [DW-1:0] p_data;
    stalled  = out_valid && !out_ready;
    aborting = abort;
    p_idx    = out_idx;
    p_data   = out_data;
    fired    = out_valid && out_ready && !abort;
    if (fired) begin
      check("beat_in_range", (exp_idx < RN) ? 1 : 0, 1);
      if (exp_idx < RN) begin
        check("beat_idx", out_idx, exp_idx);
        check("beat_data", out_data, regs[exp_idx]);
      end
      exp_idx++;
    end
    @(posedge clk);
    #1;
    if (stalled && !aborting) begin
      check("stall_valid_held", out_valid, 1);
      check("stall_idx_stable", out_idx, p_idx);
      check("stall_data_stable", out_data, p_data);
    end
    done_now = done;
  endtask

  // mode 0: ready always 1. mode 1: ready 1,0,0 repeating. mode 2: random.
  // A second start pulse is issued once when restart_at beats have been seen.
  task automatic run_dump(input int mode, input int restart_at);
    int first_fire;
    int last_fire;
    bit restarted;
    bit finished;
    exp_idx    = 0;
    first_fire = -1;
    last_fire  = -1;
    restarted  = 1'b0;
    finished   = 1'b0;
    out_ready  = 1'b0;
    start      = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (restart_at >= 0 && !restarted && exp_idx == restart_at) begin
        start     = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (cyc == 0) check("first_valid_latency", out_valid, 1);
      if (fired) begin
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      if (done_now) begin
        finished = 1'b1;
        check("done_on_last_beat", last_fire, cyc);
        check("beats_at_done", exp_idx, RN);
      end else begin
        check("busy_in_dump", busy, 1);
      end
    end
    start = 1'b0;
    check("dump_finished", finished, 1);
    if (mode == 0) check("one_beat_per_cycle", last_fire - first_fire, RN - 1);
    out_ready = 1'b0;
    step();
    check("done_one_cycle", done, 0);
    check("busy_low_after_done", busy, 0);
    check("valid_low_after_done", out_valid, 0);
    repeat (3) begin
      step();
      check("idle_no_done", done, 0);
      check("idle_not_busy", busy, 0);
    end
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < RN; i++) regs[i] = $urandom();
  endtask

  initial begin
    bit found;
    n_tests   = 0;
    n_fail    = 0;
    exp_idx   = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < RN; i++) regs[i] = 32'(i) * 32'h1111_1111;

    #12;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_data", out_data, 0);
    check("rst_raddr", raddr, 0);
    rst_n = 1'b1;
    step();

    // Full-rate dump of the i*0x11111111 pattern.
    run_dump(0, -1);

    // Backpressure 1,0,0,...
    randomize_regs();
    run_dump(1, -1);

    // Start re-pulsed while busy at beat 10 must be ignored.
    randomize_regs();
    run_dump(2, 10);

    // Abort while beat 7 is presented.
    randomize_regs();
    exp_idx   = 0;
    found     = 1'b0;
    out_ready = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !found; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (out_valid && out_idx == 5'd7) found = 1'b1;
    end
    check("abort_reached_idx7", found, 1);
    out_ready = 1'b0;
    abort     = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid_low", out_valid, 0);
    check("abort_busy_low", busy, 0);
    check("abort_no_done", done, 0);
    repeat (4) begin
      step();
      check("post_abort_no_done", done, 0);
      check("post_abort_idle", busy, 0);
    end
    randomize_regs();
    run_dump(2, -1);

    // Asynchronous reset between edges, mid-dump.
    exp_idx   = 0;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("pre_reset_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_raddr", raddr, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) begin
      step();
      check("post_rst_valid", out_valid, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
    end

    // start and abort together in IDLE: stay idle.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_valid", out_valid, 0);
    step();
    check("start_abort_busy2", busy, 0);
    check("start_abort_valid2", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
